keypad_entry_ctrl: RTL and testbench
====================================

// Module: keypad_entry_ctrl
// PURPOSE
//  Sequences raw keypad scans into committed multi-digit entries. Sits after the keypad scanner
//  (key_value/key_valid, scan-domain). Synchronises, debounces and edge-detects keys: one strobe per
//  physical press. Digit keys shift into an entry buffer; CLEAR empties it; ENTER commits it to a
//  valid/ready output port consumed by the game/ALU logic.
// PARAMETERS
//  DIGITS     4       entry buffer depth in hex digits (1..8)
//  DEBOUNCE   5000    clk cycles key input must be stable before press/release is accepted (>=2)
//  ENTER_KEY  4'hF    key code that commits the entry
//  CLEAR_KEY  4'hE    key code that clears the entry; all other codes are digits
// PORTS
//  clk          in   1          system clock; only clock
//  rst          in   1          synchronous, active-high reset
//  key_value    in   4          decoded key code from the scanner (async to clk)
//  key_valid    in   1          key-held qualifier from the scanner (async to clk)
//  entry        out  4*DIGITS   live buffer, newest digit in [3:0], for display
//  digit_count  out  4          digits currently in buffer (0..DIGITS)
//  num          out  4*DIGITS   committed number, stable while num_valid
//  num_valid    out  1          committed number available
//  num_ready    in   1          consumer accepts num when num_valid && num_ready
//  key_strobe   out  1          1-cycle pulse per accepted press
//  err          out  1          1-cycle pulse: digit on full buffer, or ENTER with empty buffer / port busy
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, debounce counter 0, sync regs 0. Reset mid-press: after release,
//    the held key is seen as a fresh press only once IDLE re-qualifies it; no state survives reset.
//  - key_value/key_valid pass a 2-flop synchroniser (kv_s, kval_s); FSM uses only synced copies.
//  - FSM: IDLE -> kval_s=1: capture code, cnt=0 -> PRESS_DB.
//    PRESS_DB: kval_s=0 or code!=captured -> IDLE; cnt==DEBOUNCE-1 -> HELD, key_strobe=1 that cycle.
//    HELD: kval_s=0 -> REL_DB, cnt=0. REL_DB: kval_s=1 -> HELD; cnt==DEBOUNCE-1 -> IDLE.
//  - Latency: stable input high from cycle N -> key_strobe in cycle N+2+DEBOUNCE. Holding a key
//    never repeats; bounce shorter than DEBOUNCE produces no strobe.
//  - Action, applied in the strobe cycle, visible on entry/digit_count next cycle:
//    digit, count<DIGITS: entry <= {entry[4*DIGITS-5:0], code}, count+1.
//    digit, count==DIGITS: buffer unchanged, err pulse.
//    CLEAR: entry<=0, count<=0 (no err, even if empty).
//    ENTER, count>0, num_valid=0: num<=entry, num_valid<=1, entry/count cleared.
//    ENTER, count==0, or num_valid=1 and num_ready=0 that cycle: ignored, err pulse.
//    ENTER while num_valid&&num_ready same cycle: handshake completes and new num loads; num_valid stays 1.
//  - num_valid drops the cycle after num_valid&&num_ready; num holds value until next commit.
//  - num zero-extends naturally (unfilled high digits are 0). count never exceeds DIGITS.
// STRUCTURE
//  - keypad_pkg: typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_t;
//    localparams KEY_W=4; default ENTER/CLEAR codes.
//  - Sub-module keypad_debouncer (sync + FSM + counter; outputs strobe + code); entry/commit logic
//    stays in keypad_entry_ctrl.
// TESTING (DIGITS=4, DEBOUNCE=4)
//  - Press '3' steady 20 cyc then release: one key_strobe at cycle N+6; entry=0x0003, count=1.
//  - Key '5' toggled every 2 cyc for 12 cyc, then steady: exactly one strobe, only after steady 4.
//  - Keys 1,2,3,4,5: entry=0x1234, count=4, err pulses once on '5'; CLEAR -> entry=0, count=0.
//  - Keys A,B,ENTER with num_ready=0: num=0x00AB, num_valid=1, entry=0; 2nd entry 7,ENTER -> err,
//    num stays 0x00AB; raise num_ready 1 cyc -> num_valid=0 next cycle.
//  - ENTER on empty buffer -> err, num_valid stays 0; rst asserted mid PRESS_DB -> outputs 0, no strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry controller.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [KEY_W-1:0] DEFAULT_ENTER_KEY = 4'hF;
  localparam logic [KEY_W-1:0] DEFAULT_CLEAR_KEY = 4'hE;

  // Debouncer FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_t;

  // What an accepted key press does to the entry buffer.
  typedef enum logic [1:0] {
    ACT_DIGIT = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_ENTER = 2'd2,
    ACT_NONE  = 2'd3
  } key_action_t;

  // Map a key code onto its buffer action; anything not ENTER/CLEAR is a digit.
  function automatic key_action_t classify_key(input logic [KEY_W-1:0] code,
                                               input logic [KEY_W-1:0] enter_key,
                                               input logic [KEY_W-1:0] clear_key);
    key_action_t act;
    if (code == enter_key) begin
      act = ACT_ENTER;
    end else if (code == clear_key) begin
      act = ACT_CLEAR;
    end else begin
      act = ACT_DIGIT;
    end
    return act;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Committed-number valid/ready port between the keypad controller and its consumer.
interface keypad_entry_ctrl_if #(
  parameter int DIGITS = 4
) ();
  import keypad_pkg::*;

  logic [KEY_W*DIGITS-1:0] num;
  logic                    num_valid;
  logic                    num_ready;

  // Producer side (keypad controller).
  modport master (
    output num,
    output num_valid,
    input  num_ready
  );

  // Consumer side (game/ALU logic).
  modport slave (
    input  num,
    input  num_valid,
    output num_ready
  );

endinterface

// File: rtl/keypad_debouncer.sv
// Synchronises the scanner's key code/qualifier and turns each physical
// press into a single strobe after DEBOUNCE stable cycles.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_value,
  input  logic             key_valid,
  output logic             strobe,
  output logic [KEY_W-1:0] code
);

  localparam int             CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [KEY_W-1:0] kv_meta_r;
  logic [KEY_W-1:0] kv_s;
  logic             kval_meta_r;
  logic             kval_s;

  kp_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [KEY_W-1:0] code_r;

  logic             press_ok_s;
  logic             cnt_done_s;

  // Two-flop synchroniser for the scan-domain key code and qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      kv_meta_r   <= 4'h0;
      kv_s        <= 4'h0;
      kval_meta_r <= 1'b0;
      kval_s      <= 1'b0;
    end else begin
      kv_meta_r   <= key_value;
      kv_s        <= kv_meta_r;
      kval_meta_r <= key_valid;
      kval_s      <= kval_meta_r;
    end
  end

  // The press stays qualified only while the same key remains held.
  assign press_ok_s = kval_s && (kv_s == code_r);
  assign cnt_done_s = (cnt_r == CNT_LAST);

  // Press/release debounce FSM; a key must be released and re-qualified to repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      code_r  <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (kval_s) begin
            code_r  <= kv_s;
            cnt_r   <= '0;
            state_r <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!press_ok_s) begin
            state_r <= IDLE;
          end else if (cnt_done_s) begin
            state_r <= HELD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        HELD: begin
          if (!kval_s) begin
            cnt_r   <= '0;
            state_r <= REL_DB;
          end
        end
        REL_DB: begin
          if (kval_s) begin
            state_r <= HELD;
          end else if (cnt_done_s) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // The strobe marks the PRESS_DB -> HELD cycle itself, decoded purely from
  // flops, so the entry logic acts on it in the same cycle.
  assign strobe = (state_r == PRESS_DB) && press_ok_s && cnt_done_s;
  assign code   = code_r;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key presses build a hex-digit entry
// that ENTER commits to a valid/ready port and CLEAR empties.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int               DIGITS    = 4,
  parameter int               DEBOUNCE  = 5000,
  parameter logic [KEY_W-1:0] ENTER_KEY = DEFAULT_ENTER_KEY,
  parameter logic [KEY_W-1:0] CLEAR_KEY = DEFAULT_CLEAR_KEY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_W-1:0]        key_value,
  input  logic                    key_valid,
  output logic [KEY_W*DIGITS-1:0] entry,
  output logic [3:0]              digit_count,
  keypad_entry_ctrl_if.master     num_port,
  output logic                    key_strobe,
  output logic                    err
);

  localparam int         ENTRY_W  = KEY_W * DIGITS;
  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  logic               strobe_s;
  logic [KEY_W-1:0]   code_s;

  logic [ENTRY_W-1:0] entry_r;
  logic [3:0]         count_r;
  logic [ENTRY_W-1:0] num_r;
  logic               num_valid_r;
  logic               err_r;

  logic [ENTRY_W-1:0] entry_nxt_s;
  logic [3:0]         count_nxt_s;
  logic [ENTRY_W-1:0] num_nxt_s;
  logic               num_valid_nxt_s;
  logic               err_nxt_s;
  logic               accept_s;

  keypad_debouncer #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clk       (clk),
    .rst       (rst),
    .key_value (key_value),
    .key_valid (key_valid),
    .strobe    (strobe_s),
    .code      (code_s)
  );

  assign accept_s = num_valid_r && num_port.num_ready;

  // Next-state of the entry buffer and commit port for the current strobe.
  always_comb begin
    entry_nxt_s     = entry_r;
    count_nxt_s     = count_r;
    num_nxt_s       = num_r;
    err_nxt_s       = 1'b0;
    // A consumed number frees the port; a commit below may refill it at once.
    if (accept_s) begin
      num_valid_nxt_s = 1'b0;
    end else begin
      num_valid_nxt_s = num_valid_r;
    end
    if (strobe_s) begin
      case (classify_key(code_s, ENTER_KEY, CLEAR_KEY))
        ACT_DIGIT: begin
          if (count_r < DIGITS_C) begin
            entry_nxt_s = (entry_r << KEY_W) | ENTRY_W'(code_s);
            count_nxt_s = count_r + 4'd1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        ACT_CLEAR: begin
          entry_nxt_s = '0;
          count_nxt_s = 4'd0;
        end
        ACT_ENTER: begin
          // Port busy means valid and not being drained in this same cycle.
          if ((count_r == 4'd0) || (num_valid_r && !num_port.num_ready)) begin
            err_nxt_s = 1'b1;
          end else begin
            num_nxt_s       = entry_r;
            num_valid_nxt_s = 1'b1;
            entry_nxt_s     = '0;
            count_nxt_s     = 4'd0;
          end
        end
        default: begin
          err_nxt_s = 1'b0;
        end
      endcase
    end else begin
      err_nxt_s = 1'b0;
    end
  end

  // Register the buffer, commit port and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_r     <= '0;
      count_r     <= 4'd0;
      num_r       <= '0;
      num_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      entry_r     <= entry_nxt_s;
      count_r     <= count_nxt_s;
      num_r       <= num_nxt_s;
      num_valid_r <= num_valid_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign entry              = entry_r;
  assign digit_count        = count_r;
  assign num_port.num       = num_r;
  assign num_port.num_valid = num_valid_r;
  assign key_strobe         = strobe_s;
  assign err                = err_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl (DIGITS=4, DEBOUNCE=4).
module tb_keypad_entry_ctrl;

  localparam int DIGITS   = 4;
  localparam int DEBOUNCE = 4;
  localparam int SD       = DEBOUNCE + 2;   // input change -> strobe cycle offset

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_value;
  logic        key_valid;
  logic [15:0] entry;
  logic [3:0]  digit_count;
  logic        key_strobe;
  logic        err;

  keypad_entry_ctrl_if #(.DIGITS(DIGITS)) nif ();

  keypad_entry_ctrl #(
    .DIGITS    (DIGITS),
    .DEBOUNCE  (DEBOUNCE),
    .ENTER_KEY (4'hF),
    .CLEAR_KEY (4'hE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_value   (key_value),
    .key_valid   (key_valid),
    .entry       (entry),
    .digit_count (digit_count),
    .num_port    (nif),
    .key_strobe  (key_strobe),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: list of entered digits (oldest first) and commit port.
  int          q[$];
  logic [15:0] m_num;
  logic        m_valid;

  function automatic logic [15:0] q_value();
    int v;
    v = 0;
    for (int i = 0; i < q.size(); i++) v = v + q[i] * (16 ** (q.size() - 1 - i));
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one press (optionally preceded by bounce), compare every cycle.
  // rc: -1 no consume, 0 ready pulse in first cycle, 1 ready pulse in strobe cycle.
  task automatic press_key(input logic [3:0] code, input int hold, input int gap,
                           input int bounce, input int rc);
    int          sk;
    logic [15:0] e_entry;
    int          e_cnt;
    logic [15:0] e_num;
    logic        e_valid;
    logic        e_err;
    logic        rdy;
    logic        acc;
    logic        committed;
    sk = bounce + SD;
    key_value    = code;
    key_valid    = 1'b1;
    nif.num_ready = (rc == 0);
    if (rc == 0) m_valid = 1'b0;
    e_entry = q_value(); e_cnt = q.size(); e_num = m_num; e_valid = m_valid; e_err = 1'b0;
    for (int k = 1; k <= bounce + hold + gap; k++) begin
      tick();
      n_vec++;
      if (key_strobe !== (k == sk)) begin
        n_bad++; $display("FAIL strobe key %h cyc %0d: got %b want %b", code, k, key_strobe, (k == sk));
      end
      n_vec++;
      if (err !== ((k == sk + 1) ? e_err : 1'b0)) begin
        n_bad++; $display("FAIL err key %h cyc %0d: got %b want %b", code, k, err, ((k == sk + 1) ? e_err : 1'b0));
      end
      n_vec++;
      if (entry !== e_entry) begin
        n_bad++; $display("FAIL entry key %h cyc %0d: got %h want %h", code, k, entry, e_entry);
      end
      n_vec++;
      if (digit_count !== 4'(e_cnt)) begin
        n_bad++; $display("FAIL count key %h cyc %0d: got %0d want %0d", code, k, digit_count, e_cnt);
      end
      n_vec++;
      if (nif.num !== e_num) begin
        n_bad++; $display("FAIL num key %h cyc %0d: got %h want %h", code, k, nif.num, e_num);
      end
      n_vec++;
      if (nif.num_valid !== e_valid) begin
        n_bad++; $display("FAIL num_valid key %h cyc %0d: got %b want %b", code, k, nif.num_valid, e_valid);
      end
      // Model the press action at the strobe, taking effect next cycle.
      if (k == sk) begin
        rdy = (rc == 1);
        nif.num_ready = rdy;
        acc = m_valid && rdy;
        committed = 1'b0;
        e_err = 1'b0;
        if (code == 4'hF) begin
          if (q.size() == 0 || (m_valid && !rdy)) e_err = 1'b1;
          else begin m_num = q_value(); committed = 1'b1; q.delete(); end
        end else if (code == 4'hE) begin
          q.delete();
        end else if (q.size() < DIGITS) begin
          q.push_back(int'(code));
        end else begin
          e_err = 1'b1;
        end
        if (committed) m_valid = 1'b1;
        else if (acc) m_valid = 1'b0;
        e_entry = q_value(); e_cnt = q.size(); e_num = m_num; e_valid = m_valid;
      end
      if (k == 1 || k == sk + 1) nif.num_ready = 1'b0;
      if (k < bounce) key_valid = ((k / 2) % 2 == 0);
      else if (k == bounce) key_valid = 1'b1;
      if (k == bounce + hold) key_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_value = 4'h0; key_valid = 1'b0; nif.num_ready = 1'b0;
    q.delete(); m_num = 16'h0000; m_valid = 1'b0;
    repeat (3) tick();
    n_vec++; if (entry !== 16'h0000) begin n_bad++; $display("FAIL reset entry: got %h want 0000", entry); end
    n_vec++; if (digit_count !== 4'd0) begin n_bad++; $display("FAIL reset count: got %0d want 0", digit_count); end
    n_vec++; if (nif.num !== 16'h0000) begin n_bad++; $display("FAIL reset num: got %h want 0000", nif.num); end
    n_vec++; if (nif.num_valid !== 1'b0) begin n_bad++; $display("FAIL reset num_valid: got %b want 0", nif.num_valid); end
    n_vec++; if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL reset strobe: got %b want 0", key_strobe); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    press_key(4'h3, 20, 8, 0, -1);
    n_vec++; if (entry !== 16'h0003) begin n_bad++; $display("FAIL single entry: got %h want 0003", entry); end
    n_vec++; if (digit_count !== 4'd1) begin n_bad++; $display("FAIL single count: got %0d want 1", digit_count); end
  endtask

  task automatic test_bounce();
    press_key(4'h5, 10, 8, 12, -1);
    n_vec++; if (entry !== 16'h0035) begin n_bad++; $display("FAIL bounce entry: got %h want 0035", entry); end
  endtask

  task automatic test_full_buffer();
    logic [3:0] seq [6];
    seq = '{4'hE, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 6; i++) press_key(seq[i], SD + 2, DEBOUNCE + 4, 0, -1);
    n_vec++; if (entry !== 16'h1234) begin n_bad++; $display("FAIL full entry: got %h want 1234", entry); end
    n_vec++; if (digit_count !== 4'd4) begin n_bad++; $display("FAIL full count: got %0d want 4", digit_count); end
    press_key(4'hE, SD + 2, DEBOUNCE + 4, 0, -1);
    n_vec++; if (entry !== 16'h0000) begin n_bad++; $display("FAIL clear entry: got %h want 0000", entry); end
    n_vec++; if (digit_count !== 4'd0) begin n_bad++; $display("FAIL clear count: got %0d want 0", digit_count); end
  endtask

  task automatic test_commit();
    press_key(4'hA, SD + 2, DEBOUNCE + 4, 0, -1);
    press_key(4'hB, SD + 2, DEBOUNCE + 4, 0, -1);
    press_key(4'hF, SD + 2, DEBOUNCE + 4, 0, -1);
    n_vec++; if (nif.num !== 16'h00AB) begin n_bad++; $display("FAIL commit num: got %h want 00ab", nif.num); end
    n_vec++; if (nif.num_valid !== 1'b1) begin n_bad++; $display("FAIL commit valid: got %b want 1", nif.num_valid); end
    n_vec++; if (entry !== 16'h0000) begin n_bad++; $display("FAIL commit entry: got %h want 0000", entry); end
    press_key(4'h7, SD + 2, DEBOUNCE + 4, 0, -1);
    press_key(4'hF, SD + 2, DEBOUNCE + 4, 0, -1);   // port busy -> err (model)
    n_vec++; if (nif.num !== 16'h00AB) begin n_bad++; $display("FAIL busy num: got %h want 00ab", nif.num); end
    // One-cycle ready pulse drains the port.
    nif.num_ready = 1'b1;
    tick();
    nif.num_ready = 1'b0;
    m_valid = 1'b0;
    n_vec++; if (nif.num_valid !== 1'b0) begin n_bad++; $display("FAIL drain valid: got %b want 0", nif.num_valid); end
    n_vec++; if (nif.num !== 16'h00AB) begin n_bad++; $display("FAIL drain num: got %h want 00ab", nif.num); end
    tick();
  endtask

  task automatic test_back_to_back();
    press_key(4'hF, SD + 2, DEBOUNCE + 4, 0, -1);   // commits pending 7
    press_key(4'h2, SD + 2, DEBOUNCE + 4, 0, -1);
    press_key(4'hF, SD + 2, DEBOUNCE + 4, 0, 1);    // drain and reload in one cycle
    n_vec++; if (nif.num !== 16'h0002) begin n_bad++; $display("FAIL b2b num: got %h want 0002", nif.num); end
    n_vec++; if (nif.num_valid !== 1'b1) begin n_bad++; $display("FAIL b2b valid: got %b want 1", nif.num_valid); end
  endtask

  task automatic test_empty_enter();
    press_key(4'hF, SD + 2, DEBOUNCE + 4, 0, 0);    // drains first, then empty ENTER
    n_vec++; if (nif.num_valid !== 1'b0) begin n_bad++; $display("FAIL empty valid: got %b want 0", nif.num_valid); end
  endtask

  task automatic test_random();
    int         r;
    logic [3:0] c;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) c = 4'($urandom_range(0, 13));
      else if (r == 7) c = 4'hE;
      else c = 4'hF;
      press_key(c, SD + 1 + $urandom_range(0, 5), DEBOUNCE + 3 + $urandom_range(0, 4),
                0, $urandom_range(0, 2) - 1);
    end
  endtask

  task automatic test_mid_reset();
    press_key(4'h9, SD + 2, DEBOUNCE + 4, 0, -1);
    key_value = 4'h6; key_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++; if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL prereset strobe cyc %0d: got %b want 0", k, key_strobe); end
    end
    rst = 1'b1; key_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    q.delete(); m_num = 16'h0000; m_valid = 1'b0;
    for (int k = 1; k <= DEBOUNCE + 6; k++) begin
      tick();
      n_vec++; if (key_strobe !== 1'b0) begin n_bad++; $display("FAIL postreset strobe cyc %0d: got %b want 0", k, key_strobe); end
      n_vec++; if (entry !== 16'h0000) begin n_bad++; $display("FAIL postreset entry cyc %0d: got %h want 0000", k, entry); end
      n_vec++; if (digit_count !== 4'd0) begin n_bad++; $display("FAIL postreset count cyc %0d: got %0d want 0", k, digit_count); end
      n_vec++; if (nif.num_valid !== 1'b0) begin n_bad++; $display("FAIL postreset valid cyc %0d: got %b want 0", k, nif.num_valid); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL postreset err cyc %0d: got %b want 0", k, err); end
    end
    // A fresh press after reset is accepted normally.
    press_key(4'h4, SD + 2, DEBOUNCE + 4, 0, -1);
    n_vec++; if (entry !== 16'h0004) begin n_bad++; $display("FAIL postreset press entry: got %h want 0004", entry); end
  endtask

  initial begin
    rst = 1'b1; key_value = 4'h0; key_valid = 1'b0; nif.num_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_full_buffer();
    test_commit();
    test_back_to_back();
    test_empty_enter();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
